// File: rtl/router_fsm_nch_if.sv
// ---------------------------------------------------------------------------
// router_fsm_nch_if
// Handshake bundle between the router control FSM and its surroundings.
//   slave  modport : the FSM view (status in, state decodes / select out)
//   master modport : the environment view (register block, FIFOs, source)
// Inputs to the FSM : pkt_valid, parity_done, low_pkt_valid, fifo_full,
//                     soft_rst[NUM_CH], fifo_empty[NUM_CH], din[ADDR_W]
// Outputs of the FSM: detect_add, lfd_state, ld_state, laf_state,
//                     full_state, drop_state, we_en_reg, rst_int_reg, busy,
//                     sel_ch[ADDR_W], drop_err
// ---------------------------------------------------------------------------
interface router_fsm_nch_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 2
);
  logic              pkt_valid;
  logic              parity_done;
  logic              low_pkt_valid;
  logic              fifo_full;
  logic [NUM_CH-1:0] soft_rst;
  logic [NUM_CH-1:0] fifo_empty;
  logic [ADDR_W-1:0] din;

  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              drop_state;
  logic              we_en_reg;
  logic              rst_int_reg;
  logic              busy;
  logic [ADDR_W-1:0] sel_ch;
  logic              drop_err;

  modport slave (
    input  pkt_valid, parity_done, low_pkt_valid, fifo_full,
           soft_rst, fifo_empty, din,
    output detect_add, lfd_state, ld_state, laf_state, full_state,
           drop_state, we_en_reg, rst_int_reg, busy, sel_ch, drop_err
  );

  modport master (
    output pkt_valid, parity_done, low_pkt_valid, fifo_full,
           soft_rst, fifo_empty, din,
    input  detect_add, lfd_state, ld_state, laf_state, full_state,
           drop_state, we_en_reg, rst_int_reg, busy, sel_ch, drop_err
  );
endinterface

// File: rtl/router_fsm_nch.sv
// ---------------------------------------------------------------------------
// router_fsm_nch
// Control FSM for a 1xN packet router. Decodes the header address, sequences
// header / payload / parity loading into the selected output FIFO, handles
// FIFO-full back-pressure, per-channel soft reset and drops packets whose
// header addresses a non-existent channel.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-low reset
//   bus  : router_fsm_nch_if.slave (see interface file for signal list)
//
// Optional feature (macro ROUTER_WAIT_TIMEOUT_EN): when defined, a packet
// waiting in WAIT_TILL_EMPTY for TIMEOUT_CYC cycles is dropped. Undefined,
// WAIT_TILL_EMPTY waits indefinitely.
// ---------------------------------------------------------------------------
module router_fsm_nch #(
  parameter int NUM_CH      = 3,
  parameter int ADDR_W      = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  router_fsm_nch_if.slave  bus
);

  localparam int              NUM_SLOT = 1 << ADDR_W;
  localparam logic [ADDR_W:0] NUM_CH_W = (ADDR_W + 1)'(NUM_CH);

  if (NUM_CH < 2 || NUM_CH > 16 || NUM_SLOT < NUM_CH || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("router_fsm_nch: illegal NUM_CH / ADDR_W / TIMEOUT_CYC combination");
  end

  typedef enum logic [3:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    LOAD_PARITY,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    WAIT_TILL_EMPTY,
    CHECK_PARITY_ERROR,
    DROP_PACKET
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sel_ch_q, sel_ch_d;
  logic              drop_err_q, drop_err_d;

  // Per-channel vectors widened to the full address space so that indexing
  // with an illegal address (or a latched illegal sel_ch) reads a defined 0.
  logic [NUM_SLOT-1:0] empty_slot;
  logic [NUM_SLOT-1:0] soft_slot;

  always_comb begin
    empty_slot             = '0;
    soft_slot              = '0;
    empty_slot[NUM_CH-1:0] = bus.fifo_empty;
    soft_slot[NUM_CH-1:0]  = bus.soft_rst;
  end

  logic addr_legal;
  logic sel_soft_rst;
  logic wait_expired;

  assign addr_legal   = ({1'b0, bus.din} < NUM_CH_W);
  assign sel_soft_rst = soft_slot[sel_ch_q];

`ifdef ROUTER_WAIT_TIMEOUT_EN
  localparam int             CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter is zero on the first WAIT_TILL_EMPTY cycle because every other
  // state clears it; expiry therefore falls on the TIMEOUT_CYC-th wait cycle.
  always_comb begin
    cnt_d = '0;
    if (state_q == WAIT_TILL_EMPTY) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign wait_expired = (cnt_q == CNT_LAST);
`else
  assign wait_expired = 1'b0;
`endif

  // NOTE: every variable gets its default before the case statement so no
  // path leaves it unassigned; that is what keeps this block free of latches.
  always_comb begin
    state_d  = state_q;
    sel_ch_d = sel_ch_q;

    case (state_q)
      DECODE_ADDRESS: begin
        if (bus.pkt_valid) begin
          sel_ch_d = bus.din;
          if (!addr_legal)              state_d = DROP_PACKET;
          else if (empty_slot[bus.din]) state_d = LOAD_FIRST_DATA;
          else                          state_d = WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        // Back-pressure outranks end-of-packet.
        if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!bus.pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (bus.parity_done)        state_d = DECODE_ADDRESS;
        else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
        else                        state_d = LOAD_DATA;
      end
      LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY: begin
        // A FIFO draining on the expiry cycle still gets the packet.
        if (empty_slot[sel_ch_q]) state_d = LOAD_FIRST_DATA;
        else if (wait_expired)    state_d = DROP_PACKET;
      end
      DROP_PACKET: begin
        if (!bus.pkt_valid) state_d = DECODE_ADDRESS;
      end
      default: state_d = DECODE_ADDRESS;
    endcase

    // Soft reset of the selected channel overrides every transition, except
    // where no channel is being served (idle decode, dropping a packet).
    if (sel_soft_rst && state_q != DECODE_ADDRESS && state_q != DROP_PACKET)
      state_d = DECODE_ADDRESS;
  end

  // Pulse only on the transition into DROP_PACKET, not while staying there.
  assign drop_err_d = (state_d == DROP_PACKET) && (state_q != DROP_PACKET);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DECODE_ADDRESS;
      sel_ch_q   <= '0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_ch_q   <= sel_ch_d;
      drop_err_q <= drop_err_d;
    end
  end

  assign bus.detect_add  = (state_q == DECODE_ADDRESS);
  assign bus.lfd_state   = (state_q == LOAD_FIRST_DATA);
  assign bus.ld_state    = (state_q == LOAD_DATA);
  assign bus.laf_state   = (state_q == LOAD_AFTER_FULL);
  assign bus.full_state  = (state_q == FIFO_FULL_STATE);
  assign bus.drop_state  = (state_q == DROP_PACKET);
  assign bus.rst_int_reg = (state_q == CHECK_PARITY_ERROR);
  assign bus.we_en_reg   = (state_q == LOAD_DATA)   ||
                           (state_q == LOAD_PARITY) ||
                           (state_q == LOAD_AFTER_FULL);
  assign bus.busy        = !((state_q == DECODE_ADDRESS) ||
                             (state_q == LOAD_DATA)      ||
                             (state_q == DROP_PACKET));
  assign bus.sel_ch      = sel_ch_q;
  assign bus.drop_err    = drop_err_q;

endmodule

// File: doc/router_fsm_nch.md
Name: router_fsm_nch

Overview:
- Parametrised control FSM for the 1xN packet router; successor to the fixed three-channel router FSM.
- Decodes the header address, sequences header/payload/parity loading into the selected output FIFO, and handles FIFO-full back-pressure and per-channel soft reset.
- New over the previous generation: N channels, illegal-address packet drop, and optional wait-for-empty timeout.
- Sits between the input register block and the FIFO write-select logic.

Parameters:
- NUM_CH, 3, number of output channels/FIFOs (2..16).
- ADDR_W, 2, header address width; must satisfy 2**ADDR_W >= NUM_CH.
- TIMEOUT_CYC, 64, WAIT_TILL_EMPTY timeout in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset; asynchronous, active-low.
- pkt_valid  in  1  packet byte valid from source.
- parity_done  in  1  parity byte captured by the register block.
- low_pkt_valid  in  1  pkt_valid fell while the FSM was in FIFO_FULL_STATE.
- fifo_full  in  1  selected FIFO full.
- soft_rst  in  NUM_CH  per-channel soft reset from the read-side timeout.
- fifo_empty  in  NUM_CH  per-channel FIFO empty.
- din  in  ADDR_W  header address bits (data_in LSBs).
- detect_add  out  1  in DECODE_ADDRESS.
- lfd_state  out  1  in LOAD_FIRST_DATA.
- ld_state  out  1  in LOAD_DATA.
- laf_state  out  1  in LOAD_AFTER_FULL.
- full_state  out  1  in FIFO_FULL_STATE.
- drop_state  out  1  in DROP_PACKET.
- we_en_reg  out  1  register-block write enable.
- rst_int_reg  out  1  in CHECK_PARITY_ERROR.
- busy  out  1  source must hold data.
- sel_ch  out  ADDR_W  latched destination channel.
- drop_err  out  1  one-cycle pulse on entry to DROP_PACKET.

Behaviour:
- Reset: async on rst=0.
  - State goes to DECODE_ADDRESS; sel_ch=0; timeout counter=0.
  - Outputs during reset: detect_add=1; all other outputs 0.
- All outputs are Moore-decoded from state, except drop_err, which is registered.
  - we_en_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = 1 in every state except DECODE_ADDRESS, LOAD_DATA and DROP_PACKET.
- sel_ch loads din only in DECODE_ADDRESS when pkt_valid=1.
- DECODE_ADDRESS:
  - pkt_valid & din<NUM_CH & fifo_empty[din] -> LOAD_FIRST_DATA.
  - pkt_valid & din<NUM_CH & !fifo_empty[din] -> WAIT_TILL_EMPTY.
  - pkt_valid & din>=NUM_CH -> DROP_PACKET, with drop_err=1 in the first DROP cycle.
  - Otherwise stay.
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally (1 cycle).
- LOAD_DATA:
  - fifo_full -> FIFO_FULL_STATE.
  - Else !pkt_valid -> LOAD_PARITY.
  - Else stay.
- FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL:
  - parity_done -> DECODE_ADDRESS.
  - Else low_pkt_valid -> LOAD_PARITY.
  - Else -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR (1 cycle).
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- WAIT_TILL_EMPTY: fifo_empty[sel_ch] -> LOAD_FIRST_DATA; else stay.
- DROP_PACKET: stay while pkt_valid=1; pkt_valid=0 -> DECODE_ADDRESS. No FIFO writes occur.
- Soft reset: soft_rst[sel_ch]=1 in any state other than DECODE_ADDRESS or DROP_PACKET forces DECODE_ADDRESS next cycle.
  - Soft reset takes priority over all other transitions.
  - soft_rst of non-selected channels is ignored.
- Simultaneous fifo_full and !pkt_valid in LOAD_DATA: full wins.
- Address boundary: NUM_CH=4 with ADDR_W=2 has no illegal address; the DROP path is unreachable but the state is still present.

Optional Feature:
- Macro: ROUTER_WAIT_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYC+1) runs in WAIT_TILL_EMPTY; it clears on entry and in every other state.
  - If fifo_empty[sel_ch] stays 0 for TIMEOUT_CYC cycles -> DROP_PACKET, with drop_err pulsed for 1 cycle.
  - fifo_empty rising on the same cycle as expiry: fifo_empty wins (-> LOAD_FIRST_DATA).
- Undefined: no counter; WAIT_TILL_EMPTY waits indefinitely; TIMEOUT_CYC is unused.

Test Plan:
- NUM_CH=3. Reset low 2 cycles -> detect_add=1, busy=0, we_en_reg=0; release, idle -> state holds.
- din=1, fifo_empty=3'b010, pkt_valid=1 for 4 cycles then 0 -> sequence LFD, LD x3, LP, CPE, DECODE; sel_ch=1; we_en_reg high for the LD and LP cycles.
- In LD, fifo_full=1 for 3 cycles; low_pkt_valid=1 on release -> FFS x3, LAF, LP, CPE; busy=1 throughout FFS/LAF.
- din=2, fifo_empty[2]=0 for 5 cycles then 1 -> WTE x5 then LFD; soft_rst[2] pulse in LD -> DECODE next cycle; soft_rst[0] is ignored.
- din=3, NUM_CH=3, pkt_valid high 6 cycles -> drop_err single pulse, drop_state x6, we_en_reg=0, then DECODE.
- With ROUTER_WAIT_TIMEOUT_EN and TIMEOUT_CYC=8, fifo_empty[sel_ch] held 0 -> DROP after 8 WTE cycles, drop_err pulse. Without the macro -> remains in WTE after 100 cycles.
